// File: rtl/ssd_scan_driver_if.sv
// Display-bus bundle between the lock status source and the seven-segment scan driver.
// The master side supplies codes and dp enables; the slave side drives the pin-level outputs.
interface ssd_scan_driver_if;
  logic [19:0] ssd_code;
  logic [3:0]  dp_mask;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  modport master (output ssd_code, dp_mask, input seg, dp, an, frame_start);
  modport slave  (input ssd_code, dp_mask, output seg, dp, an, frame_start);
endinterface

// File: rtl/ssd_scan_driver.sv
// 4-digit seven-segment scan driver: per-frame code latch, per-slot dead-time blanking,
// registered pins (1 cycle after counter state), no backpressure (free-running scan).
module ssd_scan_driver #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 1000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  ssd_scan_driver_if.slave bus
);

  localparam int TW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_CYCLES - 1);
  localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF  : 4'h0;
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = ACTIVE_LOW;

  logic [TW-1:0]   r_tick;
  logic [1:0]      r_digit;
  logic [3:0][4:0] r_frame_code;
  logic [3:0]      r_frame_dp;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_dp;
  logic            r_frame_start;

  logic [3:0][4:0] w_ssd;
  logic            w_latch;
  logic            w_blank;
  logic [4:0]      w_code;
  logic            w_dp_bit;

  function automatic logic [6:0] decode(input logic [4:0] code);
    case (code)
      5'h00: decode = 7'b1111110;
      5'h01: decode = 7'b0110000;
      5'h02: decode = 7'b1101101;
      5'h03: decode = 7'b1111001;
      5'h04: decode = 7'b0110011;
      5'h05: decode = 7'b1011011;
      5'h06: decode = 7'b1011111;
      5'h07: decode = 7'b1110000;
      5'h08: decode = 7'b1111111;
      5'h09: decode = 7'b1111011;
      5'h0A: decode = 7'b1110111;
      5'h0B: decode = 7'b0011111;
      5'h0C: decode = 7'b1001110;
      5'h0D: decode = 7'b0111101;
      5'h0E: decode = 7'b1001111;
      5'h0F: decode = 7'b1000111;
      5'h10: decode = 7'b0000000;
      5'h11: decode = 7'b0001110;
      5'h12: decode = 7'b0111101;
      5'h13: decode = 7'b1100111;
      5'h14: decode = 7'b0010101;
      default: decode = 7'b0000001;
    endcase
  endfunction

  assign w_ssd   = bus.ssd_code;
  assign w_latch = (r_digit == 2'd3) && (r_tick == '0);

  // In the latch cycle digit 3 shows the incoming code, so a new frame never starts stale.
  assign w_code   = w_latch ? w_ssd[3]       : r_frame_code[r_digit];
  assign w_dp_bit = w_latch ? bus.dp_mask[3] : r_frame_dp[r_digit];

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign w_blank = 1'b0;
    end else begin : g_blank
      assign w_blank = (r_tick < TW'(BLANK_CYCLES));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick        <= '0;
      r_digit       <= 2'd3;
      r_frame_code  <= {4{5'h10}};
      r_frame_dp    <= 4'h0;
      r_an          <= AN_OFF;
      r_seg         <= SEG_OFF;
      r_dp          <= DP_OFF;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_latch;
      if (w_latch) begin
        r_frame_code <= w_ssd;
        r_frame_dp   <= bus.dp_mask;
      end

      // Digit index wraps 0 -> 3 through natural 2-bit underflow.
      if (r_tick == TICK_LAST) begin
        r_tick  <= '0;
        r_digit <= r_digit - 2'd1;
      end else begin
        r_tick <= r_tick + 1'b1;
      end

      // XOR against the idle level applies pin polarity to the logical pattern.
      if (w_blank) begin
        r_an  <= AN_OFF;
        r_seg <= SEG_OFF;
        r_dp  <= DP_OFF;
      end else begin
        r_an  <= AN_OFF ^ (4'd1 << r_digit);
        r_seg <= SEG_OFF ^ decode(w_code);
        r_dp  <= DP_OFF ^ w_dp_bit;
      end
    end
  end

  assign bus.an          = r_an;
  assign bus.seg         = r_seg;
  assign bus.dp          = r_dp;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench: two driver instances (blanked active-low, unblanked active-high) fed identical stimulus,
// compared every cycle against a frame/slot arithmetic model of the display.
module tb_ssd_scan_driver;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ssd_scan_driver_if bus_a ();
  ssd_scan_driver_if bus_b ();

  ssd_scan_driver #(.DIGIT_CYCLES(D), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  ssd_scan_driver #(.DIGIT_CYCLES(D), .BLANK_CYCLES(0), .ACTIVE_LOW(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));

  logic [19:0] code;
  logic [3:0]  dpm;
  assign bus_a.ssd_code = code;
  assign bus_a.dp_mask  = dpm;
  assign bus_b.ssd_code = code;
  assign bus_b.dp_mask  = dpm;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt   = 0;
  bit rnd   = 1'b0;
  logic [19:0] m_code = {4{5'h10}};
  logic [3:0]  m_dp   = 4'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [4:0] c);
    logic [6:0] tbl [0:20] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011,
                               7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111,
                               7'b1000111, 7'b0000000, 7'b0001110, 7'b0111101, 7'b1100111,
                               7'b0010101};
    if (int'(c) <= 20) return tbl[int'(c)];
    return 7'b0000001;
  endfunction

  // Pins after the edge that consumed scan position c (c = edges since reset release, from 0).
  function automatic logic [11:0] pins(input int c, input int blank, input bit al,
                                       input logic [19:0] fc, input logic [3:0] fd);
    int tick = c % D;
    int dig  = 3 - ((c / D) % 4);
    logic [3:0] an = 4'h0;
    logic [6:0] s  = 7'h00;
    logic       p  = 1'b0;
    if (tick >= blank) begin
      an[dig] = 1'b1;
      s = seg_of(fc[dig*5 +: 5]);
      p = fd[dig];
    end
    if (al) return ~{an, s, p};
    return {an, s, p};
  endfunction

  task automatic check_rst();
    chk("a_rst_an", bus_a.an, 4'hF);
    chk("a_rst_seg", bus_a.seg, 7'h7F);
    chk("a_rst_dp", bus_a.dp, 1'b1);
    chk("a_rst_fs", bus_a.frame_start, 1'b0);
    chk("b_rst_an", bus_b.an, 4'h0);
    chk("b_rst_seg", bus_b.seg, 7'h00);
    chk("b_rst_dp", bus_b.dp, 1'b0);
    chk("b_rst_fs", bus_b.frame_start, 1'b0);
  endtask

  task automatic check_pos(input int c);
    logic [11:0] ea, eb;
    logic fs;
    ea = pins(c, 2, 1'b1, m_code, m_dp);
    eb = pins(c, 0, 1'b0, m_code, m_dp);
    fs = ((c % (4 * D)) == 0);
    chk("a_an", bus_a.an, ea[11:8]);
    chk("a_seg", bus_a.seg, ea[7:1]);
    chk("a_dp", bus_a.dp, ea[0]);
    chk("a_fs", bus_a.frame_start, fs);
    chk("a_onehot", ($countones(~bus_a.an) <= 1), 1'b1);
    chk("b_an", bus_b.an, eb[11:8]);
    chk("b_seg", bus_b.seg, eb[7:1]);
    chk("b_dp", bus_b.dp, eb[0]);
    chk("b_fs", bus_b.frame_start, fs);
    chk("b_onehot", ($countones(bus_b.an) == 1), 1'b1);
  endtask

  task automatic run(input int n);
    int c;
    repeat (n) begin
      @(posedge clk);
      c = cnt;
      if ((c % (4 * D)) == 0) begin
        m_code = code;
        m_dp   = dpm;
      end
      cnt++;
      @(negedge clk);
      check_pos(c);
      if (rnd && ($urandom_range(0, 7) == 0)) begin
        code = 20'($urandom);
        dpm  = 4'($urandom);
      end
    end
  endtask

  initial begin
    code = {5'h0C, 5'h11, 5'h05, 5'h12};
    dpm  = 4'h0;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    check_rst();
    rst = 1'b0;
    cnt = 0;
    run(12);
    code = {5'h00, 5'h13, 5'h0E, 5'h14};
    run(60);
    code = {5'h03, 5'h0A, 5'h1F, 5'h15};
    dpm  = 4'b0010;
    run(60);
    code = {4{5'h08}};
    dpm  = 4'hF;
    run(40);
    rnd = 1'b1;
    run(150);
    rnd = 1'b0;
    // Park in the digit 1 drive phase, then reset asynchronously.
    for (int i = 0; i < 4 * D && (cnt % (4 * D)) != 20; i++) run(1);
    chk("pre_rst_an", bus_a.an, 4'b1101);
    rst = 1'b1;
    #1;
    check_rst();
    repeat (2) @(negedge clk);
    check_rst();
    rst = 1'b0;
    cnt = 0;
    run(70);
    rnd = 1'b1;
    run(100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
